// File: rtl/clk_step_ctrl_pkg.sv
// Shared definitions for the core clock controller: FSM state encoding,
// cycle counter width and a counter-width helper.
package clk_step_ctrl_pkg;

  localparam int CYCLE_COUNT_W = 16;

  typedef enum logic [1:0] {
    S_STEP     = 2'd0,
    S_WAIT_REL = 2'd1,
    S_RUN      = 2'd2
  } state_e;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/clk_step_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser followed by a stability counter
// that accepts a level change only after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce
  import clk_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);

  logic [1:0]      sync_q;
  logic            level_q;
  logic [DB_W-1:0] cnt_q;

  // Synchronise the raw button and track how long it has disagreed with the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + DB_W'(1);
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/clk_step_ctrl.sv
// Core clock controller: free-running divided clock or debounced single-step ticks.
// Optional core tick counter on cycle_count when CLK_STEP_CYCLE_COUNT_EN is defined.
module clk_step_ctrl
  import clk_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 25000000,
  parameter int PULSE_LEN       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_btn,
  input  logic                     run_sel,
  output logic                     core_clk,
  output logic                     core_tick,
  output logic                     mode,
  output logic [CYCLE_COUNT_W-1:0] cycle_count
);

  localparam int DIV_W = cnt_width(RUN_DIV - 1);
  localparam int PLS_W = cnt_width(PULSE_LEN);

  logic             btn_level_s;
  logic             btn_rise_s;
  logic             tick_req_s;
  logic [1:0]       run_sync_q;
  logic             btn_prev_q;
  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [PLS_W-1:0] pulse_cnt_q;
  logic             core_clk_q;
  logic             core_tick_q;
  logic             mode_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (step_btn),
    .level_o(btn_level_s)
  );

  assign btn_rise_s = btn_level_s & ~btn_prev_q;

  // Next state, divider and tick request; mode changes wait for an idle, low core clock.
  always_comb begin
    state_d    = state_q;
    div_d      = '0;
    tick_req_s = 1'b0;
    case (state_q)
      S_STEP: begin
        if (btn_rise_s) begin
          tick_req_s = 1'b1;
          state_d    = S_WAIT_REL;
        end else if (run_sync_q[1] && !core_clk_q) begin
          state_d = S_RUN;
        end else begin
          state_d = S_STEP;
        end
      end
      S_WAIT_REL: begin
        if (!btn_level_s) begin
          state_d = S_STEP;
        end else if (run_sync_q[1] && !core_clk_q) begin
          state_d = S_RUN;
        end else begin
          state_d = S_WAIT_REL;
        end
      end
      S_RUN: begin
        if (div_q == DIV_W'(RUN_DIV - 1)) begin
          tick_req_s = 1'b1;
          div_d      = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
        if (!run_sync_q[1] && !core_clk_q && !tick_req_s) begin
          state_d = S_STEP;
          div_d   = '0;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_STEP;
      end
    endcase
  end

  // State, synchroniser and pulse generator; a request during a pulse is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_sync_q  <= 2'b00;
      btn_prev_q  <= 1'b0;
      state_q     <= S_STEP;
      div_q       <= '0;
      mode_q      <= 1'b0;
      core_clk_q  <= 1'b0;
      core_tick_q <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      run_sync_q <= {run_sync_q[0], run_sel};
      btn_prev_q <= btn_level_s;
      state_q    <= state_d;
      div_q      <= div_d;
      mode_q     <= (state_d == S_RUN);
      if (core_clk_q) begin
        core_tick_q <= 1'b0;
        if (pulse_cnt_q == PLS_W'(PULSE_LEN)) begin
          core_clk_q  <= 1'b0;
          pulse_cnt_q <= '0;
        end else begin
          pulse_cnt_q <= pulse_cnt_q + PLS_W'(1);
        end
      end else if (tick_req_s) begin
        core_clk_q  <= 1'b1;
        core_tick_q <= 1'b1;
        pulse_cnt_q <= PLS_W'(1);
      end else begin
        core_tick_q <= 1'b0;
      end
    end
  end

  assign core_clk  = core_clk_q;
  assign core_tick = core_tick_q;
  assign mode      = mode_q;

`ifdef CLK_STEP_CYCLE_COUNT_EN
  logic [CYCLE_COUNT_W-1:0] cyc_cnt_q;

  // Core tick counter for the debug display, wrapping naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_q <= '0;
    end else if (core_tick_q) begin
      cyc_cnt_q <= cyc_cnt_q + CYCLE_COUNT_W'(1);
    end else begin
      cyc_cnt_q <= cyc_cnt_q;
    end
  end

  assign cycle_count = cyc_cnt_q;
`else
  assign cycle_count = {CYCLE_COUNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Scoreboard bench for clk_step_ctrl: expected tick times are derived from the
// press/run timing rules and checked by an independent monitor process.
module tb_clk_step_ctrl;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int PL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_btn = 1'b0;
  logic        run_sel = 1'b0;
  logic        core_clk, core_tick, mode;
  logic [15:0] cycle_count;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int model_cnt = 0;

  typedef struct {
    int t;
    int cnt;
  } exp_t;
  exp_t exp_q[$];

  clk_step_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .RUN_DIV        (RD),
    .PULSE_LEN      (PL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .step_btn   (step_btn),
    .run_sel    (run_sel),
    .core_clk   (core_clk),
    .core_tick  (core_tick),
    .mode       (mode),
    .cycle_count(cycle_count)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_cnt(input int n);
`ifdef CLK_STEP_CYCLE_COUNT_EN
    return n % 65536;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press at the current negedge (edge k); a press held >= DB cycles ticks at edge k+DB+3.
  task automatic press(input int hold, input int gap, input bit expect_tick);
    if (expect_tick) begin
      model_cnt++;
      exp_q.push_back('{t: cyc + DB + 3, cnt: model_cnt});
    end
    step_btn = 1'b1;
    idle(hold);
    step_btn = 1'b0;
    idle(gap);
  endtask

  // True when a mode change decided in cycle c would collide with a run tick (request or pulse).
  function automatic bit run_busy(input int e, input int c);
    for (int i = 1; e + RD * i - 1 <= c; i++) begin
      if (c <= e + RD * i + PL - 1) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Hold run_sel high for len cycles; optionally hold the button through the switch back.
  task automatic run_window(input int len, input bit held);
    int r, e, f, c;
    r = cyc;
    e = r + 3;
    f = r + len;
    c = f + 2;
    while (run_busy(e, c)) c++;
    for (int i = 1; e + RD * i <= c; i++) begin
      model_cnt++;
      exp_q.push_back('{t: e + RD * i, cnt: model_cnt});
    end
    run_sel = 1'b1;
    idle(2);
    check("mode_before_entry", mode, 0);
    idle(1);
    check("mode_at_entry", mode, 1);
    if (held) step_btn = 1'b1;
    idle(len - 3);
    run_sel = 1'b0;
    idle(c - f);
    check("mode_before_exit", mode, 1);
    idle(1);
    check("mode_after_exit", mode, 0);
    idle(15);
    if (held) begin
      step_btn = 1'b0;
      idle(12);
    end
  endtask

  // Monitor: pops an expectation for every tick and checks pulse width and counter.
  initial begin
    int   hi_len;
    int   cnt_pend;
    logic prev_clk;
    exp_t e;
    hi_len   = 0;
    cnt_pend = -1;
    prev_clk = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hi_len   = 0;
        cnt_pend = -1;
        prev_clk = 1'b0;
      end else begin
        if (cnt_pend >= 0) begin
          check("cycle_count", int'(cycle_count), cnt_pend);
          cnt_pend = -1;
        end
        if (core_clk && !prev_clk) check("tick_on_rise", core_tick, 1);
        if (core_tick) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_tick: tick at cycle %0d, required none", cyc);
          end else begin
            e = exp_q.pop_front();
            check("tick_cycle", cyc, e.t);
            cnt_pend = exp_cnt(e.cnt);
          end
        end
        if (core_clk) begin
          hi_len++;
        end else if (hi_len > 0) begin
          check("pulse_len", hi_len, PL);
          hi_len = 0;
        end
        prev_clk = core_clk;
      end
    end
  end

  initial begin
    int k;
    idle(3);
    check("rst_core_clk", core_clk, 0);
    check("rst_core_tick", core_tick, 0);
    check("rst_mode", mode, 0);
    check("rst_cycle_count", int'(cycle_count), 0);
    rst = 1'b0;
    idle(5);

    // Single step: long hold, re-press, debounce boundary, random holds.
    press(20, 12, 1'b1);
    press(10, 12, 1'b1);
    press(DB, 12, 1'b1);
    press(DB - 1, 12, 1'b0);
    for (int i = 0; i < 5; i++) begin
      press($urandom_range(DB + 1, 20), $urandom_range(DB + 4, 14), 1'b1);
    end

    // Bounce shorter than the debounce window must not tick.
    for (int i = 0; i < 6; i++) begin
      step_btn = ~step_btn;
      idle(2);
    end
    step_btn = 1'b0;
    idle(12);
    for (int j = 0; j < 3; j++) begin
      int p;
      p = $urandom_range(1, DB - 1);
      for (int i = 0; i < 6; i++) begin
        step_btn = ~step_btn;
        idle(p);
      end
      step_btn = 1'b0;
      idle(12);
    end
    check("count_after_bounce", int'(cycle_count), exp_cnt(model_cnt));

    // Run mode: directed windows plus random lengths, then held button across exit.
    run_window(58, 1'b0);
    run_window(52, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_window($urandom_range(15, 60), 1'b0);
    end
    run_window(40, 1'b1);
    press(10, 12, 1'b1);

    // Asynchronous reset in the middle of a pulse.
    k = cyc;
    model_cnt++;
    exp_q.push_back('{t: k + DB + 3, cnt: model_cnt});
    step_btn = 1'b1;
    idle(DB + 5);
    check("pre_rst_core_clk", core_clk, 1);
    rst = 1'b1;
    #1;
    check("midrst_core_clk", core_clk, 0);
    check("midrst_core_tick", core_tick, 0);
    check("midrst_mode", mode, 0);
    check("midrst_cycle_count", int'(cycle_count), 0);
    model_cnt = 0;
    idle(2);
    rst = 1'b0;
    step_btn = 1'b0;
    idle(12);
    press(8, 12, 1'b1);

    idle(20);
    check("queue_empty", exp_q.size(), 0);
    check("final_cycle_count", int'(cycle_count), exp_cnt(model_cnt));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
